// File: rtl/debouncer_n.sv
// N-channel input debouncer: 2-flop synchroniser plus a per-channel stability counter.
// Define DEBOUNCER_N_EDGE_EN to enable the registered rise/fall event outputs.
module debouncer_n #(
    parameter int               WIDTH         = 2,
    parameter int               STABLE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    if (WIDTH < 1 || STABLE_CYCLES < 1) begin : g_bad_params
        $error("debouncer_n: WIDTH and STABLE_CYCLES must both be >= 1");
    end

    logic [WIDTH-1:0]            sync1_q;
    logic [WIDTH-1:0]            sync2_q;
    logic [WIDTH-1:0]            out_q, out_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every variable gets a default before the per-channel decisions, so no latch can form.
    always_comb begin
        out_d = out_q;
        cnt_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] != out_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    out_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and wins over all updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            out_q   <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out = out_q;

`ifdef DEBOUNCER_N_EDGE_EN
    logic [WIDTH-1:0] prev_out_q;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    // prev_out restarts at RESET_VAL alongside out, so reset itself never looks like an edge.
    always_comb begin
        rise_d = out_q & ~prev_out_q;
        fall_d = ~out_q & prev_out_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_out_q <= RESET_VAL;
            rise_q     <= '0;
            fall_q     <= '0;
        end else begin
            prev_out_q <= out_q;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = '0;
    assign fall = '0;
`endif

endmodule

// File: tb/tb_debouncer_n.sv
// Directed bench for debouncer_n: a STABLE_CYCLES=4 two-channel instance and a
// STABLE_CYCLES=1 single-channel instance sharing one clock and reset.
module tb_debouncer_n;

`ifdef DEBOUNCER_N_EDGE_EN
    localparam logic EDGE_EN = 1'b1;
`else
    localparam logic EDGE_EN = 1'b0;
`endif
    localparam logic [1:0] EM2 = {2{EDGE_EN}};

    logic       clk;
    logic       reset;
    logic [1:0] in;
    logic [1:0] out, rise, fall;
    logic [0:0] in1, out1, rise1, fall1;

    int checks;
    int errors;

    debouncer_n #(.WIDTH(2), .STABLE_CYCLES(4), .RESET_VAL(2'b11)) dut (
        .clk(clk), .reset(reset), .in(in), .out(out), .rise(rise), .fall(fall)
    );

    debouncer_n #(.WIDTH(1), .STABLE_CYCLES(1), .RESET_VAL(1'b1)) dut1 (
        .clk(clk), .reset(reset), .in(in1), .out(out1), .rise(rise1), .fall(fall1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [1:0] o, input logic [1:0] r,
                             input logic [1:0] f);
        check({tag, ".out"},  32'(out),  32'(o));
        check({tag, ".rise"}, 32'(rise), 32'(r));
        check({tag, ".fall"}, 32'(fall), 32'(f));
    endtask

    // New input was set just before edge E: out holds through E+4, changes at E+5,
    // the edge pulse shows after E+6 and is gone after E+7.
    task automatic expect_change(input string tag, input logic [1:0] old_out,
                                 input logic [1:0] new_out, input logic [1:0] exp_rise,
                                 input logic [1:0] exp_fall);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_all($sformatf("%s.hold%0d", tag, k), old_out, 2'b00, 2'b00);
        end
        tick();
        check_all({tag, ".land"}, new_out, 2'b00, 2'b00);
        tick();
        check_all({tag, ".pulse"}, new_out, exp_rise, exp_fall);
        tick();
        check_all({tag, ".after"}, new_out, 2'b00, 2'b00);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        reset  = 1'b1;
        in     = 2'b00;
        in1    = 1'b0;

        // Reset loads RESET_VAL even though the inputs are low.
        repeat (3) tick();
        check_all("reset", 2'b11, 2'b00, 2'b00);
        check("reset.out1", 32'(out1), 32'd1);
        check("reset.cnt0", 32'(dut.cnt_q[0]), 32'd0);

        reset = 1'b0;
        in    = 2'b11;
        in1   = 1'b1;
        repeat (3) tick();
        check_all("idle", 2'b11, 2'b00, 2'b00);

        // Channel 0 falls at E+5; channel 1 untouched.
        in = 2'b10;
        expect_change("t1_fall", 2'b11, 2'b10, 2'b00, 2'b01 & EM2);
        in = 2'b11;
        expect_change("t1_rise", 2'b10, 2'b11, 2'b01 & EM2, 2'b00);

        // Three-cycle low glitch is rejected and the counter clears.
        in = 2'b10;
        repeat (3) tick();
        in = 2'b11;
        tick();
        tick();
        check("t2.cnt_peak", 32'(dut.cnt_q[0]), 32'd3);
        check_all("t2.peak", 2'b11, 2'b00, 2'b00);
        tick();
        check("t2.cnt_clear", 32'(dut.cnt_q[0]), 32'd0);
        repeat (4) tick();
        check_all("t2.end", 2'b11, 2'b00, 2'b00);

        // Four-cycle low pulse is accepted, then out returns high four cycles later.
        in = 2'b10;
        repeat (4) tick();
        in = 2'b11;
        tick();
        check_all("t3.e4", 2'b11, 2'b00, 2'b00);
        tick();
        check_all("t3.e5", 2'b10, 2'b00, 2'b00);
        tick();
        check_all("t3.e6", 2'b10, 2'b00, 2'b01 & EM2);
        tick();
        tick();
        check_all("t3.e8", 2'b10, 2'b00, 2'b00);
        tick();
        check_all("t3.e9", 2'b11, 2'b00, 2'b00);
        tick();
        check_all("t3.e10", 2'b11, 2'b01 & EM2, 2'b00);
        tick();
        check_all("t3.e11", 2'b11, 2'b00, 2'b00);

        // Both channels fall together, then channel 1 alone rises; channel 0 stays low.
        in = 2'b00;
        expect_change("t4_both", 2'b11, 2'b00, 2'b00, 2'b11 & EM2);
        in = 2'b10;
        expect_change("t4_ch1", 2'b00, 2'b10, 2'b10 & EM2, 2'b00);

        // Reset one edge before channel 1 would land; progress is discarded.
        in = 2'b00;
        repeat (5) tick();
        check("t5.cnt1", 32'(dut.cnt_q[1]), 32'd3);
        check_all("t5.pre", 2'b10, 2'b00, 2'b00);
        reset = 1'b1;
        tick();
        check_all("t5.reset", 2'b11, 2'b00, 2'b00);
        check("t5.cnt1_clr", 32'(dut.cnt_q[1]), 32'd0);
        reset = 1'b0;
        expect_change("t5_rel", 2'b11, 2'b00, 2'b00, 2'b11 & EM2);

        // STABLE_CYCLES=1: out lands two edges after the sync stage; a 1-cycle glitch passes.
        in1 = 1'b0;
        tick();
        check("t6.e0", 32'(out1), 32'd1);
        tick();
        check("t6.e1", 32'(out1), 32'd1);
        tick();
        check("t6.e2", 32'(out1), 32'd0);
        tick();
        in1 = 1'b1;
        tick();
        in1 = 1'b0;
        tick();
        check("t6.g1", 32'(out1), 32'd0);
        tick();
        check("t6.g2", 32'(out1), 32'd1);
        tick();
        check("t6.g3", 32'(out1), 32'd0);
        check("t6.rise1", 32'(rise1), 32'(EDGE_EN));
        tick();
        check("t6.fall1", 32'(fall1), 32'(EDGE_EN));
        check("t6.rise1_off", 32'(rise1), 32'd0);
        tick();
        check("t6.fall1_off", 32'(fall1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
